// File: rtl/alu_ex_stage.sv
// rtl/alu_ex_stage.sv - 64-bit execute-stage ALU with registered result and 2-entry skid buffer
module alu_ex_stage #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic             out_zf,
    output logic             out_cf,
    output logic             out_of,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    typedef struct packed {
        logic [XLEN-1:0]  result;
        logic             zf;
        logic             cf;
        logic             of;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } entry_t;

    state_t state_q, state_d;
    entry_t p_q, p_d, s_q, s_d;
    logic   in_ready_q, in_ready_d;
    entry_t new_entry;
    logic   accept, pop;

    logic [XLEN:0]   sum;
    logic [XLEN-1:0] diff;
    logic [5:0]      shamt;

    assign sum   = {1'b0, in_a} + {1'b0, in_b};
    assign diff  = in_a - in_b;
    assign shamt = in_b[5:0];

    always_comb begin
        new_entry        = '0;
        new_entry.tag    = in_tag;
        case (in_op)
            4'd0: begin
                new_entry.result = sum[XLEN-1:0];
                new_entry.cf     = sum[XLEN];
                new_entry.of     = (in_a[XLEN-1] == in_b[XLEN-1]) && (sum[XLEN-1] != in_a[XLEN-1]);
            end
            4'd1: begin
                new_entry.result = diff;
                new_entry.cf     = in_a < in_b;
                new_entry.of     = (in_a[XLEN-1] != in_b[XLEN-1]) && (diff[XLEN-1] != in_a[XLEN-1]);
            end
            4'd2: new_entry.result = in_a & in_b;
            4'd3: new_entry.result = in_a | in_b;
            4'd4: new_entry.result = in_a ^ in_b;
            4'd5: new_entry.result = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            4'd6: new_entry.result = {{(XLEN-1){1'b0}}, in_a < in_b};
            4'd7: new_entry.result = in_a << shamt;
            4'd8: new_entry.result = in_a >> shamt;
            4'd9: new_entry.result = $unsigned($signed(in_a) >>> shamt);
            default: new_entry.ill = 1'b1;
        endcase
        new_entry.zf = (new_entry.result == '0);
    end

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign accept    = in_valid && in_ready_q;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        s_d     = s_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    p_d     = new_entry;
                    state_d = ONE;
                end
                ONE: begin
                    if (accept && pop) begin
                        p_d = new_entry;
                    end else if (accept) begin
                        s_d     = new_entry;
                        state_d = TWO;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: if (pop) begin
                    p_d     = s_q;
                    state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
        // registered ready: only the full state back-pressures upstream
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            p_q        <= '0;
            s_q        <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            s_q        <= s_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign out_result  = p_q.result;
    assign out_zf      = p_q.zf;
    assign out_cf      = p_q.cf;
    assign out_of      = p_q.of;
    assign out_illegal = p_q.ill;
    assign out_tag     = p_q.tag;
endmodule

// File: tb/tb_alu_ex_stage.sv
// tb/tb_alu_ex_stage.sv - scoreboard bench for alu_ex_stage
module tb_alu_ex_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [63:0] in_a, in_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        out_zf, out_cf, out_of, out_illegal;
    logic [4:0]  out_tag;

    typedef struct packed {
        logic [63:0] r;
        logic        zf, cf, of, ill;
        logic [4:0]  tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   npop   = 0;

    alu_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zf(out_zf), .out_cf(out_cf), .out_of(out_of),
        .out_illegal(out_illegal), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                   input logic [4:0] tag);
        exp_t e;
        logic [64:0] u, s;
        e = '0;
        e.tag = tag;
        case (op)
            4'd0: begin
                u = {1'b0, a} + {1'b0, b};
                s = {a[63], a} + {b[63], b};
                e.r = u[63:0]; e.cf = u[64]; e.of = s[64] ^ s[63];
            end
            4'd1: begin
                s = {a[63], a} - {b[63], b};
                e.r = a - b; e.cf = (a < b); e.of = s[64] ^ s[63];
            end
            4'd2: e.r = a & b;
            4'd3: e.r = a | b;
            4'd4: e.r = a ^ b;
            4'd5: e.r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd6: e.r = (a < b) ? 64'd1 : 64'd0;
            4'd7: e.r = a << b[5:0];
            4'd8: e.r = a >> b[5:0];
            4'd9: begin
                e.r = a >> b[5:0];
                if (a[63]) e.r = e.r | ~(64'hFFFF_FFFF_FFFF_FFFF >> b[5:0]);
            end
            default: e.ill = 1'b1;
        endcase
        e.zf = (e.r == 64'd0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // sample at negedge: scoreboard pop first, then flush clears, else record accept
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            npop++;
            if (sb.size() == 0) begin
                chk("unexpected_pop", {59'd0, out_tag}, 128'h1_0000);
            end else begin
                e = sb.pop_front();
                chk("sb_entry", {out_result, out_zf, out_cf, out_of, out_illegal, out_tag}, e);
            end
        end
        if (flush) sb.delete();
        else if (in_valid && in_ready) sb.push_back(model(in_op, in_a, in_b, in_tag));
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] tag);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
        in_tag = '0; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_fields", {out_result, out_zf, out_cf, out_of, out_illegal, out_tag}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        out_ready = 1'b1;
        drive(4'd6, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7); cycle(); in_valid = 1'b0;
        chk("sltu_valid", out_valid, 1);
        chk("sltu_res", {out_result, out_zf}, {64'd1, 1'b0});
        cycle();
        drive(4'd5, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8); cycle(); in_valid = 1'b0;
        chk("slt_res", {out_result, out_zf}, {64'd0, 1'b1});
        cycle();
        drive(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd9); cycle(); in_valid = 1'b0;
        chk("add_ovf", {out_result, out_of, out_cf}, {64'h8000_0000_0000_0000, 1'b1, 1'b0});
        cycle();
        drive(4'd1, 64'd0, 64'd1, 5'd10); cycle(); in_valid = 1'b0;
        chk("sub_borrow", {out_result, out_cf, out_of}, {64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0});
        cycle();
        drive(4'd12, 64'h55, 64'h33, 5'd11); cycle(); in_valid = 1'b0;
        chk("illegal", {out_illegal, out_result, out_zf}, {1'b1, 64'd0, 1'b1});
        cycle();

        // back-pressure: three back-to-back with downstream stalled
        out_ready = 1'b0;
        drive(4'd2, 64'hF0F0, 64'hFF00, 5'd1); cycle();
        drive(4'd3, 64'hF0F0, 64'h0F0F, 5'd2); cycle();
        chk("bp_in_ready_low", in_ready, 0);
        drive(4'd7, 64'h1, 64'd63, 5'd3);
        cycle(); cycle();
        chk("bp_stall_held_tag", {out_valid, out_tag}, {1'b1, 5'd1});
        chk("bp_sb_depth", sb.size(), 2);
        out_ready = 1'b1;
        cycle();
        chk("bp_second_tag", out_tag, 5'd2);
        cycle(); in_valid = 1'b0;
        chk("bp_third_tag", out_tag, 5'd3);
        cycle();
        chk("bp_drained", {out_valid, 32'(sb.size())}, 0);

        // flush while full with a new entry offered
        out_ready = 1'b0;
        drive(4'd4, 64'hAA, 64'h55, 5'd20); cycle();
        drive(4'd8, 64'h8000, 64'd4, 5'd21); cycle();
        drive(4'd9, 64'h8000_0000_0000_0000, 64'd4, 5'd22); flush = 1'b1; cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (3) cycle();

        // async reset between edges
        out_ready = 1'b0;
        drive(4'd0, 64'd5, 64'd6, 5'd30); cycle(); in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_fields", {out_result, out_zf, out_cf, out_of, out_illegal, out_tag}, 0);
        sb.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // random traffic
        npop = 0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 60) == 0);
            in_op     = 4'($urandom_range(0, 15));
            in_a      = ($urandom_range(0, 5) == 0) ? 64'h8000_0000_0000_0000 : {$urandom, $urandom};
            in_b      = ($urandom_range(0, 5) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            in_tag    = 5'($urandom);
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10 && (sb.size() != 0 || out_valid); i++) cycle();
        chk("rand_drained", {out_valid, 32'(sb.size())}, 0);
        checks++;
        assert (npop > 50) else begin
            errors++;
            $error("FAIL rand_pop_count observed=%0d expected=>50", npop);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_ex_stage.md
Name: alu_ex_stage

Overview:
- Execute-stage wrapper that sits directly upstream of the execute/memory pipeline register and consumes decoded operands from the decode stage.
- Selects among the 64-bit ALU operations, including the sltu/slt comparators, and registers result, flags and destination tag.
- Provides valid/ready handshakes on both sides, with a 2-entry skid buffer so that in_ready is a registered signal.
- Latency is one cycle from accept to out_valid when the buffer is empty.

Parameters:
- XLEN, 64, operand/result width; only 64 is supported.
- TAG_W, 5, width of the destination-register tag carried alongside the result.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  discard all held entries (branch mispredict)
- in_valid  input  1  upstream entry valid
- in_ready  output  1  stage can accept; registered
- in_op  input  4  operation select
- in_a  input  XLEN  operand A
- in_b  input  XLEN  operand B
- in_tag  input  TAG_W  destination tag
- out_valid  output  1  result entry valid
- out_ready  input  1  downstream accepts
- out_result  output  XLEN  ALU result
- out_zf  output  1  result == 0
- out_cf  output  1  carry (ADD) / borrow (SUB); 0 for other ops
- out_of  output  1  signed overflow (ADD/SUB); 0 for other ops
- out_illegal  output  1  in_op is not a defined operation
- out_tag  output  TAG_W  tag of the entry being presented

Behaviour:
- Op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLTU (unsigned).
  - 7 SLL, 8 SRL, 9 SRA; shift amount is in_b[5:0].
  - 10–15 are illegal: result 0, zf 1, cf 0, of 0, illegal 1.
- Arithmetic rules:
  - ADD and SUB are modulo 2^64.
  - ADD cf = carry out of bit 63.
  - SUB cf = 1 iff in_a < in_b unsigned (borrow).
  - of = signed overflow of the ADD/SUB.
  - SLT/SLTU result = {63'b0, compare}.
- Flags: zf is computed on the final result for every op.
- Computation is combinational on the accepted inputs; the result, flags and tag are stored as one entry.
- Storage: a primary output register P (drives the out_* ports) and a skid register S.
- State machine on count:
  - EMPTY (0): out_valid=0, in_ready=1.
  - ONE (1): P holds an entry, out_valid=1, in_ready=1.
  - TWO (2): P and S both hold entries, out_valid=1, in_ready=0.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- EMPTY: accept → entry to P → ONE.
- ONE:
  - accept & pop → new entry to P, stay ONE.
  - accept & !pop → new entry to S → TWO.
  - pop & !accept → EMPTY.
- TWO (no accept possible): pop → S moves to P → ONE.
- Ordering: strict FIFO; entries never reorder or duplicate.
- in_ready is a flop, updated every cycle from the next state: 0 only when the next state is TWO.
- Flush:
  - Synchronous; highest priority.
  - Next state is EMPTY, in_ready=1 next cycle.
  - Any same-cycle accept is dropped; any same-cycle pop is still seen by downstream, but the entry is gone next cycle.
- Reset (async, mid-operation included):
  - State EMPTY; out_valid=0, in_ready=1.
  - out_result=0, out_zf=0, out_cf=0, out_of=0, out_illegal=0, out_tag=0.
  - S contents are cleared to 0.
- Output stability: out_* fields are held stable while out_valid=1 and out_ready=0.
- Downstream stall of any length loses no data; upstream is back-pressured after two entries.

Test Plan:
- SLTU and SLT, single accept with out_ready=1:
  - op 6, a=0x1, b=0xFFFFFFFFFFFFFFFF → next cycle result=1, zf=0.
  - op 5 with the same operands → result=0, zf=1.
- ADD overflow: op 0, a=0x7FFFFFFFFFFFFFFF, b=1 → result=0x8000000000000000, of=1, cf=0.
- SUB borrow: op 1, a=0, b=1 → result=0xFFFFFFFFFFFFFFFF, cf=1, of=0.
- Illegal op: op 12 → illegal=1, result=0, zf=1.
- Back-pressure:
  - Hold out_ready=0 and issue three back-to-back ops with tags 1, 2, 3.
  - Tags 1 and 2 are accepted; in_ready=0 from the cycle after the second accept.
  - Raise out_ready → outputs appear in tag order 1, 2, then 3 after it is accepted; no loss.
- Flush in state TWO with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed entries never appear.
- Async reset asserted mid-stream (between clock edges) → out_valid drops immediately, all outputs 0, in_ready=1.
- Random stimulus: random ops, operands and handshake stalls, checked against a reference model → every result matches and the output order equals the accept order.
